// File: rtl/multicycle_control.sv
// multicycle_control: FSM sequencing FETCH/DECODE/EXEC/MEM/WB with memory stalls, wait timeout and illegal-opcode trap
module multicycle_control #(
   parameter int OPCODE_W   = 6,
   parameter int ALU_OP_W   = 3,
   parameter int WAIT_LIMIT = 16
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic                i_zero,
   input  logic                i_mem_ready,
   output logic                o_pc_write,
   output logic                o_pc_src,
   output logic                o_ir_write,
   output logic                o_mem_read,
   output logic                o_mem_write,
   output logic                o_mem_to_reg,
   output logic                o_reg_dst,
   output logic                o_reg_write,
   output logic                o_alu_src_a,
   output logic [1:0]          o_alu_src_b,
   output logic [ALU_OP_W-1:0] o_alu_op,
   output logic                o_illegal,
   output logic                o_timeout,
   output logic                o_instr_done,
   output logic [2:0]          o_state
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   // Counter must hold WAIT_LIMIT-1; keep at least one bit when the timeout is disabled
   localparam int CNT_W  = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam int LIM_M1 = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;

   localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_SLT = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(8);
   localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(10);
   localparam logic [OPCODE_W-1:0] OP_BNE = OPCODE_W'(14);

   localparam logic [ALU_OP_W-1:0] A_AND = ALU_OP_W'(0);
   localparam logic [ALU_OP_W-1:0] A_OR  = ALU_OP_W'(1);
   localparam logic [ALU_OP_W-1:0] A_ADD = ALU_OP_W'(2);
   localparam logic [ALU_OP_W-1:0] A_SUB = ALU_OP_W'(3);
   localparam logic [ALU_OP_W-1:0] A_SLT = ALU_OP_W'(4);

   state_t              r_state;
   state_t              w_next;
   logic [OPCODE_W-1:0] r_op;
   logic [CNT_W-1:0]    r_wait;
   logic [CNT_W-1:0]    w_wait_nxt;
   logic                r_illegal;
   logic                r_timeout;
   logic                w_ill_set;
   logic                w_to_set;
   logic                w_expired;
   logic                w_is_lw;
   logic                w_is_mem;
   logic                w_waiting;
   logic                w_legal;
   logic [ALU_OP_W-1:0] w_r_alu;

   assign w_legal = i_opcode inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_LW, OP_SW, OP_BNE};
   assign w_is_lw  = r_op == OP_LW;
   assign w_is_mem = w_is_lw || r_op == OP_SW;
   assign w_r_alu  = (r_op == OP_AND) ? A_AND :
                     (r_op == OP_OR)  ? A_OR  :
                     (r_op == OP_SUB) ? A_SUB :
                     (r_op == OP_SLT) ? A_SLT : A_ADD;
   assign w_waiting = (r_state == S_FETCH || r_state == S_MEM) && !i_mem_ready;
   // A handshake in the limit cycle wins because w_waiting requires mem_ready low
   assign w_expired = (WAIT_LIMIT > 0) && w_waiting && r_wait == CNT_W'(LIM_M1);
   // Counter runs only while stalled in the same state, saturating instead of wrapping
   assign w_wait_nxt = (!w_waiting || w_next != r_state) ? '0 :
                       (r_wait == '1) ? r_wait : r_wait + CNT_W'(1);
   assign o_illegal = r_illegal;
   assign o_timeout = r_timeout;
   assign o_state   = r_state;

   // Next-state and per-state datapath controls; anything not driven in a state stays 0
   always_comb begin
      w_next       = r_state;
      w_ill_set    = 1'b0;
      w_to_set     = 1'b0;
      o_pc_write   = 1'b0;
      o_pc_src     = 1'b0;
      o_ir_write   = 1'b0;
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_mem_to_reg = 1'b0;
      o_reg_dst    = 1'b0;
      o_reg_write  = 1'b0;
      o_alu_src_a  = 1'b0;
      o_alu_src_b  = 2'b00;
      o_alu_op     = A_AND;
      o_instr_done = 1'b0;
      case (r_state)
         S_FETCH: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = 2'b01;
            o_alu_op    = A_ADD;
            o_ir_write  = i_mem_ready;
            o_pc_write  = i_mem_ready;
            w_next      = i_mem_ready ? S_DECODE : w_expired ? S_TRAP : S_FETCH;
            w_to_set    = w_expired;
         end
         S_DECODE: begin
            o_alu_src_b = 2'b11;
            o_alu_op    = A_ADD;
            w_next      = w_legal ? S_EXEC : S_TRAP;
            w_ill_set   = !w_legal;
         end
         S_EXEC: begin
            o_alu_src_a = 1'b1;
            if (w_is_mem) begin
               o_alu_src_b = 2'b10;
               o_alu_op    = A_ADD;
               w_next      = S_MEM;
            end else if (r_op == OP_BNE) begin
               o_alu_op     = A_SUB;
               o_pc_src     = 1'b1;
               o_pc_write   = !i_zero;
               o_instr_done = 1'b1;
               w_next       = S_FETCH;
            end else begin
               o_alu_op = w_r_alu;
               w_next   = S_WB;
            end
         end
         S_MEM: begin
            o_mem_read   = w_is_lw;
            o_mem_write  = !w_is_lw;
            o_instr_done = i_mem_ready && !w_is_lw;
            w_next       = i_mem_ready ? (w_is_lw ? S_WB : S_FETCH) : w_expired ? S_TRAP : S_MEM;
            w_to_set     = w_expired;
         end
         S_WB: begin
            o_reg_write  = 1'b1;
            o_instr_done = 1'b1;
            o_mem_to_reg = w_is_lw;
            o_reg_dst    = !w_is_lw;
            w_next       = S_FETCH;
         end
         default: w_next = S_TRAP;
      endcase
   end

   // State, latched opcode, wait counter and sticky trap flags; reset overrides all
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= S_FETCH;
         r_op      <= '0;
         r_wait    <= '0;
         r_illegal <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_nxt;
         if (r_state == S_DECODE) r_op <= i_opcode;
         if (w_ill_set) r_illegal <= 1'b1;
         if (w_to_set) r_timeout <= 1'b1;
      end
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed vectors into a scoreboard queue, checked by a negedge monitor
module tb_multicycle_control;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg;
   logic       reg_dst, reg_write, alu_src_a, illegal, timeout, instr_done;
   logic [1:0] alu_src_b;
   logic [2:0] alu_op, state;

   typedef struct {
      logic [19:0] v;
      string       n;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_fail = 0;

   multicycle_control #(.OPCODE_W(6), .ALU_OP_W(3), .WAIT_LIMIT(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
      .o_pc_write(pc_write), .o_pc_src(pc_src), .o_ir_write(ir_write), .o_mem_read(mem_read),
      .o_mem_write(mem_write), .o_mem_to_reg(mem_to_reg), .o_reg_dst(reg_dst),
      .o_reg_write(reg_write), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
      .o_alu_op(alu_op), .o_illegal(illegal), .o_timeout(timeout),
      .o_instr_done(instr_done), .o_state(state)
   );

   always #5 clk = ~clk;

   // Layout: {state, pcw,pcs,irw,mr,mw,m2r,rd,rw,asa, alu_src_b, alu_op, illegal,timeout,done}
   wire [19:0] act = {state, pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg,
                      reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, illegal, timeout, instr_done};

   localparam logic [19:0] F_WAIT = {3'd0, 9'b000100000, 2'b01, 3'b010, 3'b000};
   localparam logic [19:0] F_GO   = {3'd0, 9'b101100000, 2'b01, 3'b010, 3'b000};
   localparam logic [19:0] DEC    = {3'd1, 9'b000000000, 2'b11, 3'b010, 3'b000};
   localparam logic [19:0] EX_MEM = {3'd2, 9'b000000001, 2'b10, 3'b010, 3'b000};
   localparam logic [19:0] BNE_T  = {3'd2, 9'b110000001, 2'b00, 3'b011, 3'b001};
   localparam logic [19:0] BNE_NT = {3'd2, 9'b010000001, 2'b00, 3'b011, 3'b001};
   localparam logic [19:0] MEM_LW = {3'd3, 9'b000100000, 2'b00, 3'b000, 3'b000};
   localparam logic [19:0] MEM_SW = {3'd3, 9'b000010000, 2'b00, 3'b000, 3'b000};
   localparam logic [19:0] SW_END = {3'd3, 9'b000010000, 2'b00, 3'b000, 3'b001};
   localparam logic [19:0] WB_R   = {3'd4, 9'b000000110, 2'b00, 3'b000, 3'b001};
   localparam logic [19:0] WB_LW  = {3'd4, 9'b000001010, 2'b00, 3'b000, 3'b001};
   localparam logic [19:0] TR_ILL = {3'd5, 9'b000000000, 2'b00, 3'b000, 3'b100};
   localparam logic [19:0] TR_TO  = {3'd5, 9'b000000000, 2'b00, 3'b000, 3'b010};

   function automatic logic [19:0] ex_r(input logic [2:0] aop);
      return {3'd2, 9'b000000001, 2'b00, aop, 3'b000};
   endfunction

   // Drive one cycle of inputs just after the edge and queue what the outputs must be
   task automatic step(input logic [5:0] op, input logic z, input logic rdy, input logic [19:0] e, input string nm);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      opcode = op;
      zero = z;
      mem_ready = rdy;
      q.push_back('{e, nm});
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      mem_ready = 1'b0;
   endtask

   // Monitor: compare whatever the stimulus queued for this cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", e.n, act, e.v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] r_ops [4] = '{6'd0, 6'd1, 6'd6, 6'd7};
      logic [2:0] r_aop [4] = '{3'b000, 3'b001, 3'b011, 3'b100};
      do_reset();
      do_reset();
      step(6'd2, 0, 0, F_WAIT, "reset_fetch");
      step(6'd2, 0, 1, F_GO, "add_fetch");
      step(6'd2, 0, 1, DEC, "add_decode");
      step(6'd2, 0, 1, ex_r(3'b010), "add_exec");
      step(6'd2, 0, 1, WB_R, "add_wb");
      for (int i = 0; i < 4; i++) begin
         step(r_ops[i], 0, 1, F_GO, "r_fetch");
         step(r_ops[i], 0, 1, DEC, "r_decode");
         step(r_ops[i], 0, 1, ex_r(r_aop[i]), "r_exec_aluop");
         step(r_ops[i], 0, 1, WB_R, "r_wb");
      end
      step(6'd8, 0, 1, F_GO, "lw_fetch");
      step(6'd8, 0, 1, DEC, "lw_decode");
      step(6'd8, 0, 0, EX_MEM, "lw_exec");
      step(6'd8, 0, 0, MEM_LW, "lw_mem_wait1");
      step(6'd8, 0, 0, MEM_LW, "lw_mem_wait2");
      step(6'd8, 0, 0, MEM_LW, "lw_mem_wait3");
      step(6'd8, 0, 1, MEM_LW, "lw_mem_ready");
      step(6'd8, 0, 1, WB_LW, "lw_wb");
      step(6'd14, 0, 1, F_GO, "bne_fetch");
      step(6'd14, 0, 1, DEC, "bne_decode");
      step(6'd14, 0, 1, BNE_T, "bne_taken");
      step(6'd14, 1, 1, F_GO, "bne2_fetch");
      step(6'd14, 1, 1, DEC, "bne2_decode");
      step(6'd14, 1, 1, BNE_NT, "bne_not_taken");
      step(6'd10, 0, 1, F_GO, "sw_fetch");
      step(6'd10, 0, 1, DEC, "sw_decode");
      step(6'd10, 0, 0, EX_MEM, "sw_exec");
      step(6'd10, 0, 0, MEM_SW, "sw_mem_wait");
      step(6'd10, 0, 1, SW_END, "sw_mem_done");
      step(6'd5, 0, 1, F_GO, "ill_fetch");
      step(6'd5, 0, 1, DEC, "ill_decode");
      for (int i = 0; i < 10; i++) step(6'd8, 0, i[0], TR_ILL, "ill_trap_hold");
      do_reset();
      step(6'd2, 0, 0, F_WAIT, "ill_reset_clears");
      do_reset();
      step(6'd2, 0, 0, F_WAIT, "to_wait0");
      step(6'd2, 0, 0, F_WAIT, "to_wait1");
      step(6'd2, 0, 0, F_WAIT, "to_wait2");
      step(6'd2, 0, 0, F_WAIT, "to_wait3");
      step(6'd2, 0, 1, TR_TO, "to_trap");
      step(6'd2, 0, 1, TR_TO, "to_trap_hold");
      do_reset();
      step(6'd2, 0, 0, F_WAIT, "hs_wait0");
      step(6'd2, 0, 0, F_WAIT, "hs_wait1");
      step(6'd2, 0, 0, F_WAIT, "hs_wait2");
      step(6'd2, 0, 1, F_GO, "hs_ready_last");
      step(6'd2, 0, 1, DEC, "hs_decode_no_to");
      step(6'd2, 0, 1, ex_r(3'b010), "hs_exec");
      step(6'd2, 0, 1, WB_R, "hs_wb");
      step(6'd10, 0, 1, F_GO, "swr_fetch");
      step(6'd10, 0, 1, DEC, "swr_decode");
      step(6'd10, 0, 0, EX_MEM, "swr_exec");
      step(6'd10, 0, 0, MEM_SW, "swr_mem");
      do_reset();
      step(6'd10, 0, 0, F_WAIT, "swr_after_reset");
      step(6'd10, 0, 0, F_WAIT, "swr_no_done");
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
